// File: rtl/atto_pkg.sv
// Shared constants for the atto_core_p register-file core: opcodes, FSM
// state encoding, ALU operation codes and fixed register roles.
package atto_pkg;

    // Opcodes live in the top three bits of IR.
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_JMP = 3'd1;
    localparam logic [2:0] OP_ALU = 3'd2;
    localparam logic [2:0] OP_LDI = 3'd3;
    localparam logic [2:0] OP_LD  = 3'd4;
    localparam logic [2:0] OP_ST  = 3'd5;
    localparam logic [2:0] OP_MOV = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_IMM,
        ST_MRD,
        ST_MWR,
        ST_HALT
    } state_e;

    // ALU operation codes (IR[3:0]); 8..15 pass A through.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;

    // Fixed register roles; r8 and above are general purpose.
    localparam int unsigned R_ADDR_L = 0;
    localparam int unsigned R_ADDR_H = 1;
    localparam int unsigned R_PC_L   = 2;
    localparam int unsigned R_PC_H   = 3;
    localparam int unsigned R_IR     = 4;
    localparam int unsigned R_A      = 5;
    localparam int unsigned R_B      = 6;
    localparam int unsigned R_Y      = 7;

endpackage

// File: rtl/atto_core_p_if.sv
// Split read/write memory port with a req/ready handshake.
// The core is the master; memory or the bus fabric is the slave.
interface atto_core_p_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/atto_alu_p.sv
// Combinational ALU for atto_core_p: DATA_W-bit result, no flags.
module atto_alu_p
    import atto_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    // Decode the operation; unlisted codes pass A through.
    always_comb begin
        y_o = a_i;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_NOT: y_o = ~a_i;
            ALU_SHL: y_o = {a_i[DATA_W-2:0], 1'b0};
            ALU_SHR: y_o = {1'b0, a_i[DATA_W-1:1]};
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/atto_core_p.sv
// Parametrised multicycle register-file core. PC, address pointer, IR and
// ALU operands all live in the register file; memory is reached through a
// split read/write port whose ready input may insert wait states.
module atto_core_p
    import atto_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned REG_CNT = 16
) (
    input  logic              clock,
    input  logic              reset,
    atto_core_p_if.master     mem,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc
);

    localparam int unsigned RIDX_W = $clog2(REG_CNT);
    localparam int unsigned PAIR_W = 2 * DATA_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [RIDX_W-1:0] ridx_t;
    typedef logic [PAIR_W-1:0] pair_t;

    localparam ridx_t IDX_ADDR_L = ridx_t'(R_ADDR_L);
    localparam ridx_t IDX_ADDR_H = ridx_t'(R_ADDR_H);
    localparam ridx_t IDX_PC_L   = ridx_t'(R_PC_L);
    localparam ridx_t IDX_PC_H   = ridx_t'(R_PC_H);
    localparam ridx_t IDX_IR     = ridx_t'(R_IR);
    localparam ridx_t IDX_A      = ridx_t'(R_A);
    localparam ridx_t IDX_B      = ridx_t'(R_B);
    localparam ridx_t IDX_Y      = ridx_t'(R_Y);

    word_t             regs_q [REG_CNT];
    word_t             regs_d [REG_CNT];
    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              halted_q, halted_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    word_t             wdata_q, wdata_d;

    // Decoded instruction fields and register-pair views.
    logic [2:0]        opcode;
    ridx_t             idx;
    logic [3:0]        aluop;
    pair_t             pc_pair_q, ad_pair_q;
    logic [ADDR_W-1:0] pc_q, pc_inc;
    logic              xfer;
    logic              jmp_taken;
    ridx_t             mov_src, mov_dst;
    word_t             alu_y;

    // Register-file write ports: one general port plus the PC pair.
    logic              wr_en;
    ridx_t             wr_idx;
    word_t             wr_data;
    logic              pc_we;
    logic [ADDR_W-1:0] pc_new;
    pair_t             pc_wr;
    pair_t             pc_pair_d, ad_pair_d;

    assign opcode    = regs_q[IDX_IR][DATA_W-1 -: 3];
    assign idx       = regs_q[IDX_IR][RIDX_W-1:0];
    assign aluop     = regs_q[IDX_IR][3:0];
    assign pc_pair_q = {regs_q[IDX_PC_H], regs_q[IDX_PC_L]};
    assign ad_pair_q = {regs_q[IDX_ADDR_H], regs_q[IDX_ADDR_L]};
    assign pc_q      = pc_pair_q[ADDR_W-1:0];
    assign pc_inc    = pc_q + 1'b1;
    assign xfer      = req_q & mem.mem_ready;
    // Conditional form (IR[0]=1) falls through when r7[0] is clear.
    assign jmp_taken = !(regs_q[IDX_IR][0] && !regs_q[IDX_Y][0]);
    assign mov_src   = mem.mem_rdata[2*RIDX_W-1:RIDX_W];
    assign mov_dst   = mem.mem_rdata[RIDX_W-1:0];

    atto_alu_p #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i (aluop),
        .a_i  (regs_q[IDX_A]),
        .b_i  (regs_q[IDX_B]),
        .y_o  (alu_y)
    );

    // Next state and register-file writes; nothing moves unless a transfer completes.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        pc_we   = 1'b0;
        pc_new  = pc_inc;

        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    wr_idx  = IDX_IR;
                    wr_data = mem.mem_rdata;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                case (opcode)
                    OP_JMP: begin
                        pc_we  = jmp_taken;
                        pc_new = ad_pair_q[ADDR_W-1:0];
                    end
                    OP_ALU: begin
                        wr_en   = 1'b1;
                        wr_idx  = IDX_Y;
                        wr_data = alu_y;
                    end
                    OP_LDI, OP_MOV: state_d = ST_IMM;
                    OP_LD:          state_d = ST_MRD;
                    OP_ST:          state_d = ST_MWR;
                    OP_HLT:         state_d = ST_HALT;
                    default:        state_d = ST_FETCH;
                endcase
            end
            ST_IMM: begin
                if (xfer) begin
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                    if (opcode == OP_LDI) begin
                        wr_en   = 1'b1;
                        wr_idx  = idx;
                        wr_data = mem.mem_rdata;
                    end else if (mov_src != mov_dst) begin
                        wr_en   = 1'b1;
                        wr_idx  = mov_dst;
                        wr_data = regs_q[mov_src];
                    end
                end
            end
            ST_MRD: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    wr_idx  = idx;
                    wr_data = mem.mem_rdata;
                    state_d = ST_FETCH;
                end
            end
            ST_MWR: begin
                if (xfer) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase

        // PC update first so a same-cycle write to r2/r3 overrides its byte.
        regs_d = regs_q;
        pc_wr  = pc_pair_q;
        pc_wr[ADDR_W-1:0] = pc_new;
        if (pc_we) begin
            regs_d[IDX_PC_H] = pc_wr[PAIR_W-1:DATA_W];
            regs_d[IDX_PC_L] = pc_wr[DATA_W-1:0];
        end
        if (wr_en) begin
            regs_d[wr_idx] = wr_data;
        end
    end

    // Memory-port outputs for the cycle after this edge, derived from next state.
    always_comb begin
        pc_pair_d = {regs_d[IDX_PC_H], regs_d[IDX_PC_L]};
        ad_pair_d = {regs_d[IDX_ADDR_H], regs_d[IDX_ADDR_L]};
        // Leaving RST spends one idle FETCH cycle before the first request.
        req_d     = (state_q != ST_RST) &&
                    (state_d inside {ST_FETCH, ST_IMM, ST_MRD, ST_MWR});
        we_d      = req_d && (state_d == ST_MWR);
        addr_d    = '0;
        if (req_d) begin
            addr_d = (state_d inside {ST_MRD, ST_MWR}) ? ad_pair_d[ADDR_W-1:0]
                                                        : pc_pair_d[ADDR_W-1:0];
        end
        wdata_d   = we_d ? regs_d[idx] : '0;
        halted_d  = (state_d == ST_HALT);
    end

    // State, register file and registered port outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RST;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b0;
            for (int unsigned i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
            regs_q   <= regs_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign halted        = halted_q;
    assign dbg_pc        = pc_q;

endmodule

// File: tb/tb_atto_core_p.sv
// Self-checking bench for atto_core_p: programs are loaded into a byte memory
// model, expected store transactions are queued up front and matched against
// the stores the core actually performs.
module tb_atto_core_p;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        halted;
    logic [15:0] dbg_pc;

    always #5 clock = ~clock;

    atto_core_p_if #(.DATA_W(8), .ADDR_W(16)) mem_bus ();

    atto_core_p #(
        .DATA_W  (8),
        .ADDR_W  (16),
        .REG_CNT (16)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .mem    (mem_bus),
        .halted (halted),
        .dbg_pc (dbg_pc)
    );

    // Memory model: combinational read data, selectable ready source.
    logic [7:0]  mem_arr [0:65535];
    logic        man_ready = 1'b1;
    logic        rnd_ready = 1'b1;
    logic        rand_mode = 1'b0;
    logic [15:0] wp;

    assign mem_bus.mem_ready = rand_mode ? rnd_ready : man_ready;
    assign mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];

    always @(negedge clock) rnd_ready <= ($urandom_range(0, 2) != 0);

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  passed = 0;
    int  total  = 0;

    // Record every completed write transfer.
    always @(posedge clock) begin
        if (!reset && mem_bus.mem_req && mem_bus.mem_ready && mem_bus.mem_we)
            obs_q.push_back({mem_bus.mem_addr, mem_bus.mem_wdata});
    end

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem_arr[i] = 8'hE0;
        wp = 16'h0000;
    endtask

    task automatic org(input logic [15:0] a);
        wp = a;
    endtask

    task automatic put(input logic [7:0] b);
        mem_arr[wp] = b;
        wp = wp + 16'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        obs_q.delete();
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input int max, output bit timeout);
        int n = 0;
        while (!halted && n < max) begin
            @(posedge clock);
            #1;
            n++;
        end
        timeout = !halted;
    endtask

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            default: return a;
        endcase
    endfunction

    task automatic test_reset();
        clear_mem();
        man_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++; if (mem_bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_bus.mem_req); else passed++;
        total++; if (mem_bus.mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", mem_bus.mem_we); else passed++;
        total++; if (mem_bus.mem_addr !== 16'h0) $display("FAIL reset_addr: got %h want 0000", mem_bus.mem_addr); else passed++;
        total++; if (mem_bus.mem_wdata !== 8'h0) $display("FAIL reset_wdata: got %h want 00", mem_bus.mem_wdata); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passed++;
        total++; if (dbg_pc !== 16'h0) $display("FAIL reset_pc: got %h want 0000", dbg_pc); else passed++;
        reset = 1'b0;
        @(posedge clock); #1;
        total++; if (mem_bus.mem_req !== 1'b0) $display("FAIL edge1_req: got %b want 0", mem_bus.mem_req); else passed++;
        @(posedge clock); #1;
        total++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== 16'h0)
            $display("FAIL edge2_fetch: got req=%b we=%b addr=%h want req=1 we=0 addr=0000",
                     mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr);
        else passed++;
    endtask

    task automatic test_program();
        bit to;
        wr_t e, o;
        clear_mem();
        put(8'h65); put(8'h12); put(8'h66); put(8'h34); put(8'h40);
        put(8'h60); put(8'h00); put(8'h61); put(8'h80); put(8'hA7); put(8'hE0);
        exp_q.push_back({16'h8000, 8'h46});
        man_ready = 1'b1;
        do_reset();
        run_to_halt(200, to);
        total++; if (to) $display("FAIL prog_halt: got halted=0 want 1"); else passed++;
        total++; if (dbg_pc !== 16'd11) $display("FAIL prog_pc: got %h want 000b", dbg_pc); else passed++;
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL prog_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL prog_write: got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
            else passed++;
        end
        exp_q.delete();
    endtask

    task automatic test_alu_ops(input bit rnd);
        bit          to;
        wr_t         e, o;
        logic [3:0]  op;
        logic [7:0]  a = 8'h96;
        logic [7:0]  b = 8'h3C;
        clear_mem();
        put(8'h65); put(a); put(8'h66); put(b); put(8'h61); put(8'h80);
        for (int i = 0; i < 10; i++) begin
            op = (i == 9) ? 4'd15 : 4'(i);
            put(8'h40 | {4'h0, op}); put(8'h60); put(8'(i)); put(8'hA7);
            exp_q.push_back({16'h8000 | 16'(i), alu_model(op, a, b)});
        end
        put(8'hE0);
        rand_mode = rnd;
        man_ready = 1'b1;
        do_reset();
        run_to_halt(3000, to);
        rand_mode = 1'b0;
        total++; if (to) $display("FAIL alu_halt(rnd=%0d): got halted=0 want 1", rnd); else passed++;
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL alu_count(rnd=%0d): got %0d want %0d", rnd, obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL alu_write(rnd=%0d): got %h:%h want %h:%h", rnd, o.addr, o.data, e.addr, e.data);
            else passed++;
        end
        exp_q.delete();
    endtask

    task automatic test_wait_states();
        clear_mem();
        put(8'h00);
        man_ready = 1'b0;
        do_reset();
        @(posedge clock); #1;
        @(posedge clock); #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== 16'h0 || dbg_pc !== 16'h0)
                $display("FAIL wait_hold[%0d]: got req=%b we=%b addr=%h pc=%h want 1 0 0000 0000",
                         k, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, dbg_pc);
            else passed++;
            if (k == 3) man_ready = 1'b1;
            @(posedge clock); #1;
        end
        total++; if (dbg_pc !== 16'h1) $display("FAIL wait_pc_step: got %h want 0001", dbg_pc); else passed++;
        man_ready = 1'b0;
        @(posedge clock); #1;
        total++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h1)
            $display("FAIL wait_refetch: got req=%b addr=%h want 1 0001", mem_bus.mem_req, mem_bus.mem_addr);
        else passed++;
        reset = 1'b1;
        @(posedge clock); #1;
        total++; if (mem_bus.mem_req !== 1'b0) $display("FAIL reset_abandon: got req=%b want 0", mem_bus.mem_req); else passed++;
        man_ready = 1'b1;
    endtask

    task automatic test_jmp();
        bit  to;
        wr_t e, o;
        clear_mem();
        put(8'h67); put(8'h00); put(8'h60); put(8'h34); put(8'h61); put(8'h12);
        put(8'h21); put(8'h68); put(8'hAA); put(8'hA8);
        put(8'h67); put(8'h01); put(8'h21);
        org(16'h1234);
        put(8'h68); put(8'hBB); put(8'hA8); put(8'h67); put(8'h00);
        put(8'h60); put(8'h00); put(8'h61); put(8'h20); put(8'h20);
        org(16'h2000);
        put(8'h68); put(8'hCC); put(8'hA8);
        exp_q.push_back({16'h1234, 8'hAA});
        exp_q.push_back({16'h1234, 8'hBB});
        exp_q.push_back({16'h2000, 8'hCC});
        man_ready = 1'b1;
        do_reset();
        run_to_halt(400, to);
        total++; if (to) $display("FAIL jmp_halt: got halted=0 want 1"); else passed++;
        total++; if (dbg_pc !== 16'h2004) $display("FAIL jmp_pc: got %h want 2004", dbg_pc); else passed++;
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL jmp_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL jmp_write: got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
            else passed++;
        end
        exp_q.delete();
    endtask

    task automatic test_mov_ld();
        bit  to;
        wr_t e, o;
        clear_mem();
        put(8'h65); put(8'hAB); put(8'hC0); put(8'h58);
        put(8'h60); put(8'h00); put(8'h61); put(8'h80); put(8'hA8);
        put(8'h61); put(8'h90); put(8'h89); put(8'h61); put(8'h80); put(8'hA9);
        put(8'hC0); put(8'h88); put(8'hA8);
        mem_arr[16'h9000] = 8'h5A;
        exp_q.push_back({16'h8000, 8'hAB});
        exp_q.push_back({16'h8000, 8'h5A});
        exp_q.push_back({16'h8000, 8'hAB});
        man_ready = 1'b1;
        do_reset();
        run_to_halt(300, to);
        total++; if (to) $display("FAIL mov_halt: got halted=0 want 1"); else passed++;
        total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL mov_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL mov_write: got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
            else passed++;
        end
        exp_q.delete();
    endtask

    task automatic test_halt();
        bit to;
        int bad = 0;
        clear_mem();
        man_ready = 1'b1;
        do_reset();
        run_to_halt(20, to);
        total++; if (to) $display("FAIL hlt_reach: got halted=0 want 1"); else passed++;
        repeat (50) begin
            @(posedge clock); #1;
            if (halted !== 1'b1 || mem_bus.mem_req !== 1'b0) bad++;
        end
        total++; if (bad != 0) $display("FAIL hlt_hold: got %0d bad cycles want 0", bad); else passed++;
        reset = 1'b1;
        @(posedge clock); #1;
        total++; if (halted !== 1'b0) $display("FAIL hlt_reset: got halted=%b want 0", halted); else passed++;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        total++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0)
            $display("FAIL hlt_restart: got req=%b addr=%h want 1 0000", mem_bus.mem_req, mem_bus.mem_addr);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_program();
        test_alu_ops(1'b0);
        test_wait_states();
        test_jmp();
        test_mov_ld();
        test_alu_ops(1'b1);
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/atto_core_p.md
Name: atto_core_p

Overview:
Parametrised successor to the team's 8-bit multicycle register-file core. Generalises data width and register count, and replaces the bidirectional data bus with a split read/write memory port. The port uses a req/ready handshake, so memory may insert wait states. Adds an ALU-op set, a halt opcode and a debug PC. Sits between program/data memory (or the bus fabric) and nothing else.

Parameters:
DATA_W, 8, register/data width; must be ≥ 8.
ADDR_W, 16, memory address width; must be ≤ 2*DATA_W.
REG_CNT, 16, number of registers; power of two, 16 or 32; 2*log2(REG_CNT) ≤ DATA_W.

Ports:
clock  in  1  sole clock; all state on rising edge.
reset  in  1  synchronous, active-high.
mem_req  out  1  transfer request, registered.
mem_we  out  1  1 = write, 0 = read; valid while mem_req.
mem_addr  out  ADDR_W  transfer address.
mem_wdata  out  DATA_W  write data.
mem_rdata  in  DATA_W  read data, sampled on the edge where mem_req&mem_ready.
mem_ready  in  1  completes the current transfer.
halted  out  1  core stopped by HLT.
dbg_pc  out  ADDR_W  current PC.

Behaviour:
- Register roles (RIDX_W = log2(REG_CNT)):
  - ADDR = {r1,r0}[ADDR_W-1:0]; PC = {r3,r2}[ADDR_W-1:0]; r4 = IR; r5/r6 = ALU A/B; r7 = ALU Y; r8+ general.
  - PC increments wrap modulo 2^ADDR_W.
- Instruction fields: opcode = IR[DATA_W-1:DATA_W-3]; idx = IR[RIDX_W-1:0]; aluop = IR[3:0].
- Reset:
  - All registers 0; state RST.
  - mem_req, mem_we, mem_addr, mem_wdata, halted all 0.
  - Reset mid-transfer abandons the transfer; mem_req is 0 on the next edge.
- States:
  - RST → FETCH.
  - FETCH: req=1, we=0, addr=PC. On ready: IR<=rdata, PC+=1, → DECODE.
  - DECODE, by opcode:
    - 0 NOP → FETCH.
    - 1 JMP: if IR[0]=1 and r7[0]=0, not taken; else PC<=ADDR. → FETCH.
    - 2 ALU: r7<=alu(aluop,r5,r6) → FETCH.
    - 3 LDI → IMM.
    - 4 LD → MRD.
    - 5 ST → MWR.
    - 6 MOV → IMM.
    - 7 HLT → HALT.
  - IMM: req=1, addr=PC. On ready, PC+=1, then:
    - LDI: r[idx]<=rdata.
    - MOV: r[rdata[RIDX_W-1:0]] <= r[rdata[2*RIDX_W-1:RIDX_W]].
    - → FETCH.
  - MRD: req=1, addr=ADDR. On ready r[idx]<=rdata → FETCH.
  - MWR: req=1, we=1, addr=ADDR, wdata=r[idx]. On ready → FETCH.
  - HALT: req=0, halted=1; only reset exits.
- Handshake:
  - addr, we and wdata are stable while req=1 and ready=0. PC and registers do not change while waiting.
  - Exactly one transfer occurs per req&ready edge. req may stay high across back-to-back transfers.
  - ready is ignored while req=0.
- Latency at zero wait:
  - NOP/JMP/ALU: 2 cycles.
  - LDI/LD/ST/MOV: 3 cycles.
  - Each wait cycle adds 1.
- Write conflicts:
  - A register write targeting r2/r3 in IMM overrides that byte of the PC increment.
  - A write targeting r4 lands after decode and has no effect on the current instruction.
  - MOV with src=dst is a no-op.
- ALU ops, DATA_W result, no flags:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A (logical) by 1.
  - 8..15 pass A.

Decomposition:
- Package atto_pkg holds:
  - opcode constants (OP_NOP..OP_HLT);
  - state encoding (ST_RST, ST_FETCH, ST_DECODE, ST_IMM, ST_MRD, ST_MWR, ST_HALT);
  - ALU op constants;
  - register-role indices (R_ADDR_L, R_PC_L, R_IR, R_A, R_B, R_Y).
- Sub-module atto_alu_p (combinational, parameter DATA_W) implements the ALU.

Test Plan (DATA_W=8, ADDR_W=16, REG_CNT=16):
1. Reset: hold reset 3 cycles → all outputs 0. After release, edge 1 req=0; edge 2 req=1, we=0, addr=0x0000.
2. Program LDI r5 0x12; LDI r6 0x34; ALU ADD (0x40); LDI r0 0x00; LDI r1 0x80; ST r7 (0xA7) → write transfer addr=0x8000, wdata=0x46.
3. Fetch with ready delayed 3 cycles → addr/we constant for 4 cycles. dbg_pc increments exactly once, on the ready edge.
4. JMP 0x21 with r7=0x00 → fetch continues at PC+1. With r7=0x01 and r1:r0=0x1234 → next fetch addr=0x1234. JMP 0x20 jumps regardless of r7.
5. r5=0xAB, MOV (0xC0) with imm 0x58 → r8=0xAB. Checked via ST r8 showing wdata=0xAB.
6. HLT (0xE0) → halted=1, req=0 for 50 cycles. Reset → halted=0 and fetch restarts at 0x0000.
